// File: rtl/riscv_decoder_if.sv
// Instruction/decoded-control bundle between fetch and the RV32I decoder.
// The illegal_inst_out signal exists only when RISCV_DECODER_ILLEGAL_EN is defined.
interface riscv_decoder_if;
  logic [31:0] inst_in;
  logic [4:0]  rs1_out;
  logic [4:0]  rs2_out;
  logic [4:0]  rd_out;
  logic [31:0] imm_out;
  logic [2:0]  br_func_out;
  logic [1:0]  pc_sel_out;
  logic        op1_sel_out;
  logic        op2_sel_out;
  logic [1:0]  writeback_sel_out;
  logic [3:0]  alu_func_out;
  logic        write_enable_rf_out;
  logic        dmem_func_out;
  logic [2:0]  dmem_size_out;
  logic        dmem_enable_out;
`ifdef RISCV_DECODER_ILLEGAL_EN
  logic        illegal_inst_out;
`endif

  modport master (
    output inst_in,
    input  rs1_out, rs2_out, rd_out, imm_out, br_func_out, pc_sel_out,
    input  op1_sel_out, op2_sel_out, writeback_sel_out, alu_func_out,
    input  write_enable_rf_out, dmem_func_out, dmem_size_out, dmem_enable_out
`ifdef RISCV_DECODER_ILLEGAL_EN
    , input illegal_inst_out
`endif
  );

  modport slave (
    input  inst_in,
    output rs1_out, rs2_out, rd_out, imm_out, br_func_out, pc_sel_out,
    output op1_sel_out, op2_sel_out, writeback_sel_out, alu_func_out,
    output write_enable_rf_out, dmem_func_out, dmem_size_out, dmem_enable_out
`ifdef RISCV_DECODER_ILLEGAL_EN
    , output illegal_inst_out
`endif
  );
endinterface

// File: rtl/riscv_decoder.sv
// RV32I instruction decoder: register indices, immediate and datapath controls, 1-cycle registered.
// Define RISCV_DECODER_ILLEGAL_EN to add the registered illegal_inst_out flag.
module riscv_decoder (
  input  logic           clk_in,
  input  logic           rst_n_in,
  riscv_decoder_if.slave dec
);

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JAL    = 2'd2;
  localparam logic [1:0] PC_JALR   = 2'd3;

  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_LOAD   = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;
  localparam logic [1:0] WB_IMM    = 2'd3;

  localparam logic       OP1_RS1   = 1'b0;
  localparam logic       OP1_PC    = 1'b1;
  localparam logic       OP2_RS2   = 1'b0;
  localparam logic       OP2_IMM   = 1'b1;

  localparam logic       DMEM_LOAD  = 1'b0;
  localparam logic       DMEM_STORE = 1'b1;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [2:0] BR_IDLE    = 3'b010;
  localparam logic [6:0] FUNCT7_STD = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  br_func;
    logic [1:0]  pc_sel;
    logic        op1_sel;
    logic        op2_sel;
    logic [1:0]  wb_sel;
    logic [3:0]  alu_func;
    logic        we;
    logic        dmem_func;
    logic [2:0]  dmem_size;
    logic        dmem_en;
  } ctrl_t;

  logic [31:0] inst;
  opcode_e     opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [4:0]  rd_f;
  logic [31:0] imm_i;
  logic [31:0] imm_sh;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic  illegal;

  assign inst   = dec.inst_in;
  assign opcode = opcode_e'(inst[6:0]);
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rs1_f  = inst[19:15];
  assign rs2_f  = inst[24:20];
  assign rd_f   = inst[11:7];

  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_sh = {27'b0, inst[24:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};

  // NOTE: every field gets a default before the case so no path leaves a latch behind.
  always_comb begin
    ctrl_d         = '0;
    ctrl_d.br_func = BR_IDLE;
    illegal        = 1'b0;

    case (opcode)
      OPC_LUI: begin
        ctrl_d.rd     = rd_f;
        ctrl_d.imm    = imm_u;
        ctrl_d.wb_sel = WB_IMM;
        ctrl_d.we     = 1'b1;
      end

      OPC_AUIPC: begin
        ctrl_d.rd       = rd_f;
        ctrl_d.imm      = imm_u;
        ctrl_d.op1_sel  = OP1_PC;
        ctrl_d.op2_sel  = OP2_IMM;
        ctrl_d.alu_func = ALU_ADD;
        ctrl_d.wb_sel   = WB_ALU;
        ctrl_d.we       = 1'b1;
      end

      OPC_JAL: begin
        ctrl_d.rd       = rd_f;
        ctrl_d.imm      = imm_j;
        ctrl_d.pc_sel   = PC_JAL;
        ctrl_d.op1_sel  = OP1_PC;
        ctrl_d.op2_sel  = OP2_IMM;
        ctrl_d.alu_func = ALU_ADD;
        ctrl_d.wb_sel   = WB_PC4;
        ctrl_d.we       = 1'b1;
      end

      OPC_JALR: begin
        ctrl_d.rd       = rd_f;
        ctrl_d.rs1      = rs1_f;
        ctrl_d.imm      = imm_i;
        ctrl_d.pc_sel   = PC_JALR;
        ctrl_d.op1_sel  = OP1_RS1;
        ctrl_d.op2_sel  = OP2_IMM;
        ctrl_d.alu_func = ALU_ADD;
        ctrl_d.wb_sel   = WB_PC4;
        ctrl_d.we       = 1'b1;
      end

      OPC_BRANCH: begin
        ctrl_d.rs1      = rs1_f;
        ctrl_d.rs2      = rs2_f;
        ctrl_d.imm      = imm_b;
        ctrl_d.br_func  = funct3;
        ctrl_d.pc_sel   = PC_BRANCH;
        ctrl_d.op1_sel  = OP1_PC;
        ctrl_d.op2_sel  = OP2_IMM;
        ctrl_d.alu_func = ALU_ADD;
        illegal         = (funct3 == 3'b010) || (funct3 == 3'b011);
      end

      OPC_LOAD: begin
        ctrl_d.rd        = rd_f;
        ctrl_d.rs1       = rs1_f;
        ctrl_d.imm       = imm_i;
        ctrl_d.op1_sel   = OP1_RS1;
        ctrl_d.op2_sel   = OP2_IMM;
        ctrl_d.alu_func  = ALU_ADD;
        ctrl_d.dmem_en   = 1'b1;
        ctrl_d.dmem_func = DMEM_LOAD;
        ctrl_d.dmem_size = funct3;
        ctrl_d.wb_sel    = WB_LOAD;
        ctrl_d.we        = 1'b1;
        illegal          = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end

      OPC_STORE: begin
        ctrl_d.rs1       = rs1_f;
        ctrl_d.rs2       = rs2_f;
        ctrl_d.imm       = imm_s;
        ctrl_d.op1_sel   = OP1_RS1;
        ctrl_d.op2_sel   = OP2_IMM;
        ctrl_d.alu_func  = ALU_ADD;
        ctrl_d.dmem_en   = 1'b1;
        ctrl_d.dmem_func = DMEM_STORE;
        ctrl_d.dmem_size = funct3;
        illegal          = (funct3 > 3'b010);
      end

      OPC_OP_IMM: begin
        ctrl_d.rd       = rd_f;
        ctrl_d.rs1      = rs1_f;
        ctrl_d.op1_sel  = OP1_RS1;
        ctrl_d.op2_sel  = OP2_IMM;
        ctrl_d.wb_sel   = WB_ALU;
        ctrl_d.we       = 1'b1;
        ctrl_d.alu_func = {1'b0, funct3};
        ctrl_d.imm      = imm_i;
        // Shift-immediates reuse the funct7 field, so only shamt is the operand.
        if (funct3 == 3'b001) begin
          ctrl_d.imm = imm_sh;
          illegal    = (funct7 != FUNCT7_STD);
        end else if (funct3 == 3'b101) begin
          ctrl_d.imm         = imm_sh;
          ctrl_d.alu_func[3] = inst[30];
          illegal            = (funct7 != FUNCT7_STD) && (funct7 != FUNCT7_ALT);
        end
      end

      OPC_OP: begin
        ctrl_d.rd       = rd_f;
        ctrl_d.rs1      = rs1_f;
        ctrl_d.rs2      = rs2_f;
        ctrl_d.op1_sel  = OP1_RS1;
        ctrl_d.op2_sel  = OP2_RS2;
        ctrl_d.wb_sel   = WB_ALU;
        ctrl_d.we       = 1'b1;
        ctrl_d.alu_func = {1'b0, funct3};
        if ((funct3 == 3'b000) || (funct3 == 3'b101)) begin
          ctrl_d.alu_func[3] = inst[30];
          illegal            = (funct7 != FUNCT7_STD) && (funct7 != FUNCT7_ALT);
        end else begin
          illegal = (funct7 != FUNCT7_STD);
        end
      end

      OPC_MISC_MEM, OPC_SYSTEM: begin
        ctrl_d.br_func = BR_IDLE;
      end

      default: begin
        illegal = 1'b1;
      end
    endcase

    // Illegal encodings collapse to the same NOP as FENCE/SYSTEM.
    if (illegal) begin
      ctrl_d         = '0;
      ctrl_d.br_func = BR_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

`ifdef RISCV_DECODER_ILLEGAL_EN
  logic illegal_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal;
    end
  end

  assign dec.illegal_inst_out = illegal_q;
`endif

  assign dec.rs1_out             = ctrl_q.rs1;
  assign dec.rs2_out             = ctrl_q.rs2;
  assign dec.rd_out              = ctrl_q.rd;
  assign dec.imm_out             = ctrl_q.imm;
  assign dec.br_func_out         = ctrl_q.br_func;
  assign dec.pc_sel_out          = ctrl_q.pc_sel;
  assign dec.op1_sel_out         = ctrl_q.op1_sel;
  assign dec.op2_sel_out         = ctrl_q.op2_sel;
  assign dec.writeback_sel_out   = ctrl_q.wb_sel;
  assign dec.alu_func_out        = ctrl_q.alu_func;
  assign dec.write_enable_rf_out = ctrl_q.we;
  assign dec.dmem_func_out       = ctrl_q.dmem_func;
  assign dec.dmem_size_out       = ctrl_q.dmem_size;
  assign dec.dmem_enable_out     = ctrl_q.dmem_en;

endmodule

// File: tb/tb_riscv_decoder.sv
// Scoreboard bench for riscv_decoder: directed RV32I vectors plus random instructions vs. a behavioural model.
// Checks illegal_inst_out too when RISCV_DECODER_ILLEGAL_EN is defined.
module tb_riscv_decoder;

  logic clk_in = 1'b0;
  logic rst_n_in;

  always #5 clk_in = ~clk_in;

  riscv_decoder_if dif ();

  riscv_decoder dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .dec      (dif)
  );

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  br_func;
    logic [1:0]  pc_sel;
    logic        op1;
    logic        op2;
    logic [1:0]  wb;
    logic [3:0]  alu;
    logic        we;
    logic        dfunc;
    logic [2:0]  dsize;
    logic        den;
    logic        illegal;
  } exp_t;

  typedef enum {K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD, K_ST, K_OPI, K_OP, K_NOP} kind_e;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v,
                       input logic [31:0] inst);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (inst %h) at %0t", name, act, exp_v, inst, $time);
    end
  endtask

  function automatic exp_t reset_exp(input logic [31:0] i);
    exp_t e;
    e = '{default: '0};
    e.inst = i;
    return e;
  endfunction

  // Reference: classify the instruction, decide legality, then fill fields from the RV32I tables.
  function automatic exp_t model(input logic [31:0] i);
    exp_t       e;
    kind_e      k;
    logic       legal;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       alt;
    int         v;
    op    = i[6:0];
    f3    = i[14:12];
    f7    = i[31:25];
    legal = 1'b1;
    k     = K_NOP;
    case (op)
      7'h37: k = K_LUI;
      7'h17: k = K_AUIPC;
      7'h6f: k = K_JAL;
      7'h67: k = K_JALR;
      7'h63: begin k = K_BR; legal = !(f3 inside {3'd2, 3'd3}); end
      7'h03: begin k = K_LD; legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; end
      7'h23: begin k = K_ST; legal = f3 inside {3'd0, 3'd1, 3'd2}; end
      7'h13: begin
        k = K_OPI;
        if (f3 == 3'd1)      legal = (f7 == 7'h00);
        else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
      end
      7'h33: begin
        k     = K_OP;
        legal = (f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'h0f, 7'h73: k = K_NOP;
      default: begin k = K_NOP; legal = 1'b0; end
    endcase
    if (!legal) k = K_NOP;

    e         = '{default: '0};
    e.inst    = i;
    e.illegal = !legal;
    e.br_func = 3'b010;
    case (k)
      K_LUI: begin
        e.rd = i[11:7]; e.imm = {i[31:12], 12'h000}; e.wb = 2'd3; e.we = 1'b1;
      end
      K_AUIPC: begin
        e.rd = i[11:7]; e.imm = {i[31:12], 12'h000};
        e.op1 = 1'b1; e.op2 = 1'b1; e.we = 1'b1;
      end
      K_JAL: begin
        v = $signed({i[31], i[19:12], i[20], i[30:21]}) * 2;
        e.rd = i[11:7]; e.imm = v; e.pc_sel = 2'd2; e.wb = 2'd2; e.we = 1'b1;
        e.op1 = 1'b1; e.op2 = 1'b1;
      end
      K_JALR: begin
        v = $signed(i[31:20]);
        e.rd = i[11:7]; e.rs1 = i[19:15]; e.imm = v; e.pc_sel = 2'd3; e.wb = 2'd2;
        e.we = 1'b1; e.op2 = 1'b1;
      end
      K_BR: begin
        v = $signed({i[31], i[7], i[30:25], i[11:8]}) * 2;
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.imm = v; e.br_func = f3; e.pc_sel = 2'd1;
        e.op1 = 1'b1; e.op2 = 1'b1;
      end
      K_LD: begin
        v = $signed(i[31:20]);
        e.rd = i[11:7]; e.rs1 = i[19:15]; e.imm = v; e.den = 1'b1; e.dsize = f3;
        e.wb = 2'd1; e.we = 1'b1; e.op2 = 1'b1;
      end
      K_ST: begin
        v = $signed({i[31:25], i[11:7]});
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.imm = v; e.den = 1'b1; e.dfunc = 1'b1;
        e.dsize = f3; e.op2 = 1'b1;
      end
      K_OPI: begin
        v = $signed(i[31:20]);
        alt = (f3 == 3'd5) ? i[30] : 1'b0;
        e.rd = i[11:7]; e.rs1 = i[19:15]; e.op2 = 1'b1; e.we = 1'b1;
        e.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(i[24:20]) : v;
        e.alu = {alt, f3};
      end
      K_OP: begin
        alt = (f3 == 3'd0 || f3 == 3'd5) ? i[30] : 1'b0;
        e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.we = 1'b1;
        e.alu = {alt, f3};
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  opc;
    int          sel;
    r   = $urandom();
    sel = $urandom_range(0, 11);
    case (sel)
      0: opc = 7'h37;
      1: opc = 7'h17;
      2: opc = 7'h6f;
      3: opc = 7'h67;
      4: opc = 7'h63;
      5: opc = 7'h03;
      6: opc = 7'h23;
      7: opc = 7'h13;
      8: opc = 7'h33;
      9: opc = ($urandom_range(0, 1) == 0) ? 7'h0f : 7'h73;
      default: opc = r[6:0];
    endcase
    if ((opc == 7'h13 || opc == 7'h33) && $urandom_range(0, 3) != 0)
      r[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
    return {r[31:7], opc};
  endfunction

  task automatic drive(input logic rst_n, input logic [31:0] i);
    rst_n_in    = rst_n;
    dif.inst_in = i;
    sb_q.push_back(rst_n ? model(i) : reset_exp(i));
    @(negedge clk_in);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("rs1",     32'(dif.rs1_out),             32'(e.rs1),     e.inst);
        check("rs2",     32'(dif.rs2_out),             32'(e.rs2),     e.inst);
        check("rd",      32'(dif.rd_out),              32'(e.rd),      e.inst);
        check("imm",     dif.imm_out,                  e.imm,          e.inst);
        check("br_func", 32'(dif.br_func_out),         32'(e.br_func), e.inst);
        check("pc_sel",  32'(dif.pc_sel_out),          32'(e.pc_sel),  e.inst);
        check("op1_sel", 32'(dif.op1_sel_out),         32'(e.op1),     e.inst);
        check("op2_sel", 32'(dif.op2_sel_out),         32'(e.op2),     e.inst);
        check("wb_sel",  32'(dif.writeback_sel_out),   32'(e.wb),      e.inst);
        check("alu",     32'(dif.alu_func_out),        32'(e.alu),     e.inst);
        check("we",      32'(dif.write_enable_rf_out), 32'(e.we),      e.inst);
        check("d_func",  32'(dif.dmem_func_out),       32'(e.dfunc),   e.inst);
        check("d_size",  32'(dif.dmem_size_out),       32'(e.dsize),   e.inst);
        check("d_en",    32'(dif.dmem_enable_out),     32'(e.den),     e.inst);
`ifdef RISCV_DECODER_ILLEGAL_EN
        check("illegal", 32'(dif.illegal_inst_out),    32'(e.illegal), e.inst);
`endif
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: run exceeded time limit at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  logic [31:0] directed [$] = '{
    32'h000cb197, 32'hff1fff6f, 32'h00208763, 32'hfe80a583, 32'hfeb0a423,
    32'h4088d493, 32'h40838333, 32'h0000000f, 32'h00000073, 32'h00000000,
    32'h02000033, 32'h40001013, 32'h00003003, 32'h00002063, 32'h00003023,
    32'h800000b7, 32'h0040c0e7, 32'h0080d093, 32'h00729233, 32'hfff4e513
  };

  initial begin : stimulus
    drive(1'b0, 32'h00208763);
    drive(1'b0, 32'h00208763);
    foreach (directed[n]) drive(1'b1, directed[n]);
    for (int n = 0; n < 1500; n++) drive(1'b1, rand_inst());
    drive(1'b0, rand_inst());
    for (int n = 0; n < 300; n++) drive(1'b1, rand_inst());
    drive(1'b1, 32'h00000013);
    @(negedge clk_in);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
